// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the signed BCD display formatter.
package sd_pkg;

  localparam int DIGITS = 9;
  localparam int BCD_W  = 36;
  localparam int MAG_W  = 33;
  localparam int ITER   = 28;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABS     = 3'd1,
    ST_CONVERT = 3'd2,
    ST_DONE    = 3'd3,
    ST_ACCUM   = 3'd4
  } state_t;

endpackage

// File: rtl/sd_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module sd_bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/sd_bcd_formatter.sv
// Signed ADC result to sign + 9-digit BCD with overrange clamp, fixed 30-cycle latency.
// Optional 4-sample averaging front end is compiled in with `define SD_BCD_AVG_EN.
//
// state      | meaning
// IDLE       | waiting for a sample (in_ready=1)
// ACCUM      | collecting samples 2..4 into the sum (averaging build only)
// ABS        | clamp magnitude against FULL_SCALE, load shift source
// CONVERT    | 28 add-3/shift iterations, then latch result
// DONE       | result valid, held until out_ready
module sd_bcd_formatter
  import sd_pkg::*;
#(
  parameter int unsigned FULL_SCALE = 199999999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MAG_W-1:0]  sample_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [BCD_W-1:0]  bcd_out,
  output logic              overrange
);

  localparam logic [MAG_W-1:0] FS = MAG_W'(FULL_SCALE);

  state_t             state;
  logic [MAG_W-1:0]   mag;
  logic [ITER-1:0]    src;
  logic [BCD_W-1:0]   work;
  logic [BCD_W-1:0]   adj;
  logic [4:0]         iter_cnt;
  logic [MAG_W-1:0]   value;
  logic [MAG_W-1:0]   value_mag;
  logic               accept;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    sd_bcd_digit_adj u_adj (
      .digit_in  (work[4*d +: 4]),
      .digit_out (adj[4*d +: 4])
    );
  end

`ifdef SD_BCD_AVG_EN
  logic signed [MAG_W+1:0] acc;
  logic signed [MAG_W+1:0] sum;
  logic signed [MAG_W+1:0] avg;
  logic [1:0]              acc_cnt;

  assign sum      = acc + $signed({{2{sample_in[MAG_W-1]}}, sample_in});
  assign avg      = sum >>> 2;
  assign value    = avg[MAG_W-1:0];
  assign in_ready = (state == ST_IDLE) || (state == ST_ACCUM);
`else
  assign value    = sample_in;
  assign in_ready = (state == ST_IDLE);
`endif

  // Two's-complement negate as unsigned: -2^32 maps to 2^32 without overflow.
  assign value_mag = value[MAG_W-1] ? (~value + 1'b1) : value;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      sign      <= 1'b0;
      bcd_out   <= '0;
      overrange <= 1'b0;
      mag       <= '0;
      src       <= '0;
      work      <= '0;
      iter_cnt  <= '0;
`ifdef SD_BCD_AVG_EN
      acc       <= '0;
      acc_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
`ifdef SD_BCD_AVG_EN
            acc     <= $signed({{2{sample_in[MAG_W-1]}}, sample_in});
            acc_cnt <= 2'd1;
            state   <= ST_ACCUM;
`else
            mag   <= value_mag;
            sign  <= value[MAG_W-1];
            state <= ST_ABS;
`endif
          end
        end
`ifdef SD_BCD_AVG_EN
        ST_ACCUM: begin
          if (accept) begin
            if (acc_cnt == 2'd3) begin
              mag     <= value_mag;
              sign    <= value[MAG_W-1];
              acc     <= '0;
              acc_cnt <= '0;
              state   <= ST_ABS;
            end else begin
              acc     <= sum;
              acc_cnt <= acc_cnt + 2'd1;
            end
          end
        end
`endif
        ST_ABS: begin
          if (mag > FS) begin
            src       <= FS[ITER-1:0];
            overrange <= 1'b1;
          end else begin
            src       <= mag[ITER-1:0];
            overrange <= 1'b0;
          end
          work     <= '0;
          iter_cnt <= 5'(ITER);
          state    <= ST_CONVERT;
        end
        ST_CONVERT: begin
          if (iter_cnt != 5'd0) begin
            {work, src} <= {adj[BCD_W-2:0], src, 1'b0};
            iter_cnt    <= iter_cnt - 5'd1;
          end else begin
            bcd_out   <= work;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_bcd_formatter.sv
// Directed-vector bench for sd_bcd_formatter; averaging vectors run when SD_BCD_AVG_EN is defined.
module tb_sd_bcd_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic [32:0] sample_in;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [35:0] bcd_out;
  logic        overrange;

  int vectors     = 0;
  int miscompares = 0;

  sd_bcd_formatter dut (
    .clk       (clk),
    .reset     (reset),
    .sample_in (sample_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .bcd_out   (bcd_out),
    .overrange (overrange)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One accept; clk is low when called, returns #1 after the accept edge.
  task automatic accept_one(input string tag, input logic [32:0] s);
    @(negedge clk);
    sample_in = s;
    in_valid  = 1'b1;
    #1;
    check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    sample_in = '0;
  endtask

  // Feeds the sample(s), measures latency from the final accept, checks result, then handshakes.
  task automatic run(input string tag, input logic [32:0] s0, input logic [32:0] s1,
                     input logic [32:0] s2, input logic [32:0] s3,
                     input logic exp_sign, input logic [35:0] exp_bcd, input logic exp_ovr,
                     input bit noisy);
    int cnt;
    accept_one(tag, s0);
`ifdef SD_BCD_AVG_EN
    accept_one(tag, s1);
    accept_one(tag, s2);
    accept_one(tag, s3);
`endif
    if (noisy) begin
      in_valid  = 1'b1;
      sample_in = 33'd7;
    end
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, ":latency"}, 64'(cnt), 64'd30);
    check({tag, ":sign"}, 64'(sign), 64'(exp_sign));
    check({tag, ":bcd"}, 64'(bcd_out), 64'(exp_bcd));
    check({tag, ":ovr"}, 64'(overrange), 64'(exp_ovr));
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ":ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset     = 1'b1;
    sample_in = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:bcd", 64'(bcd_out), 64'd0);
    check("rst:sign", 64'(sign), 64'd0);
    check("rst:ovr", 64'(overrange), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst:in_ready", 64'(in_ready), 64'd1);

    run("v123", 33'd123456789, 33'd123456789, 33'd123456789, 33'd123456789,
        1'b0, 36'h123456789, 1'b0, 1'b1);
    run("vneg1", 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF,
        1'b1, 36'h000000001, 1'b0, 1'b0);
    run("vzero", 33'd0, 33'd0, 33'd0, 33'd0, 1'b0, 36'h0, 1'b0, 1'b0);
    run("vfs", 33'd199999999, 33'd199999999, 33'd199999999, 33'd199999999,
        1'b0, 36'h199999999, 1'b0, 1'b0);
    run("vover", 33'd200000000, 33'd200000000, 33'd200000000, 33'd200000000,
        1'b0, 36'h199999999, 1'b1, 1'b0);
    run("vmin", 33'h1_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000,
        1'b1, 36'h199999999, 1'b1, 1'b0);
`ifdef SD_BCD_AVG_EN
    run("avg_pos", 33'd10, 33'd11, 33'd12, 33'd13, 1'b0, 36'h000000011, 1'b0, 1'b0);
    run("avg_neg", 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFE,
        1'b1, 36'h000000002, 1'b0, 1'b0);
`endif

    // Backpressure: result held for 10 cycles with out_ready low.
    accept_one("hold", 33'd42);
`ifdef SD_BCD_AVG_EN
    accept_one("hold", 33'd42);
    accept_one("hold", 33'd42);
    accept_one("hold", 33'd42);
`endif
    repeat (30) @(posedge clk);
    #1;
    check("hold:valid_rise", 64'(out_valid), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check("hold:valid", 64'(out_valid), 64'd1);
    check("hold:bcd", 64'(bcd_out), 64'h42);
    check("hold:sign", 64'(sign), 64'd0);
    check("hold:ovr", 64'(overrange), 64'd0);
    check("hold:in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hold:in_ready_after", 64'(in_ready), 64'd1);

    // Reset 15 cycles into conversion of a negative sample.
    accept_one("mid", 33'h1_FFFF_FF85);
`ifdef SD_BCD_AVG_EN
    accept_one("mid", 33'h1_FFFF_FF85);
    accept_one("mid", 33'h1_FFFF_FF85);
    accept_one("mid", 33'h1_FFFF_FF85);
`endif
    repeat (15) @(posedge clk);
    #1;
    check("mid:sign_pre", 64'(sign), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid:out_valid", 64'(out_valid), 64'd0);
    check("mid:bcd", 64'(bcd_out), 64'd0);
    check("mid:sign", 64'(sign), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid:in_ready", 64'(in_ready), 64'd1);

    run("post_rst", 33'd987654321 - 33'd900000000, 33'd87654321, 33'd87654321, 33'd87654321,
        1'b0, 36'h087654321, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
